// File: rtl/adder_result_stage_if.sv
// rtl/adder_result_stage_if.sv - word stream bundle between prefix_adder and its result stage
interface adder_result_stage_if #(
  parameter int width = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             in_first;
  logic             in_last;
  logic [width-1:0] in_sum;
  logic             in_cout;
  logic             in_a_msb;
  logic             in_b_msb;
  logic             out_valid;
  logic             out_ready;
  logic [width-1:0] out_sum;
  logic             out_last;
  logic [3:0]       out_flags;

  // Result stage side: consumes adder words, produces registered results.
  modport slave (
    input  in_valid, in_first, in_last, in_sum, in_cout, in_a_msb, in_b_msb, out_ready,
    output in_ready, out_valid, out_sum, out_last, out_flags
  );

  // Environment side: supplies adder words and sinks results.
  modport master (
    output in_valid, in_first, in_last, in_sum, in_cout, in_a_msb, in_b_msb, out_ready,
    input  in_ready, out_valid, out_sum, out_last, out_flags
  );
endinterface

// File: rtl/adder_result_stage.sv
// rtl/adder_result_stage.sv - registered skid-buffered result stage with carry chaining and NZCV flags
module adder_result_stage #(
  parameter int width = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cin_ext,
  output logic                 adder_cin,
  adder_result_stage_if.slave  bus
);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_MAIN  = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

  occ_t             occ_q;
  occ_t             occ_d;
  logic             accept;
  logic             drain;
  logic             load_main;
  logic             load_skid;
  logic             move_skid;

  logic             carry_q;
  logic             zero_acc;
  logic             zero_word;
  logic             zero_new;
  logic             ovf_word;
  logic [3:0]       flags_word;

  logic [width-1:0] main_sum;
  logic             main_last;
  logic [3:0]       main_flags;
  logic [width-1:0] skid_sum;
  logic             skid_last;
  logic [3:0]       skid_flags;

  // The skid entry is only ever occupied in FULL, so readiness is a pure register decode.
  assign bus.in_ready  = (occ_q != OCC_FULL);
  assign bus.out_valid = (occ_q != OCC_EMPTY);
  assign bus.out_sum   = main_sum;
  assign bus.out_last  = main_last;
  assign bus.out_flags = main_flags;

  assign accept = bus.in_valid & bus.in_ready;
  assign drain  = bus.out_valid & bus.out_ready;

  // A first word always seeds from cin_ext, so a stray in_first silently restarts the chain.
  assign adder_cin = bus.in_first ? cin_ext : carry_q;

  assign zero_word  = (bus.in_sum == '0);
  assign zero_new   = (bus.in_first | zero_acc) & zero_word;
  assign ovf_word   = (bus.in_a_msb == bus.in_b_msb) & (bus.in_sum[width-1] != bus.in_a_msb);
  assign flags_word = bus.in_last ? {bus.in_sum[width-1], zero_new, bus.in_cout, ovf_word} : 4'b0000;

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ_q <= OCC_EMPTY;
    else        occ_q <= occ_d;
  end

  // Occupancy next-state and entry load strobes; accept+drain together keeps occupancy.
  always_comb begin
    occ_d     = occ_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (occ_q)
      OCC_EMPTY: begin
        if (accept) begin
          load_main = 1'b1;
          occ_d     = OCC_MAIN;
        end
      end
      OCC_MAIN: begin
        if (accept && drain) begin
          load_main = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          occ_d     = OCC_FULL;
        end else if (drain) begin
          occ_d     = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (drain) begin
          move_skid = 1'b1;
          occ_d     = OCC_MAIN;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
  end

  // Main entry drives the outputs; it changes only on load or skid promotion, so it holds under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_sum   <= '0;
      main_last  <= 1'b0;
      main_flags <= 4'b0000;
    end else if (load_main) begin
      main_sum   <= bus.in_sum;
      main_last  <= bus.in_last;
      main_flags <= flags_word;
    end else if (move_skid) begin
      main_sum   <= skid_sum;
      main_last  <= skid_last;
      main_flags <= skid_flags;
    end
  end

  // Skid entry catches the word accepted while main is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_sum   <= '0;
      skid_last  <= 1'b0;
      skid_flags <= 4'b0000;
    end else if (load_skid) begin
      skid_sum   <= bus.in_sum;
      skid_last  <= bus.in_last;
      skid_flags <= flags_word;
    end
  end

  // Chain state: carry and running all-zero tracker for multi-word sums.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q  <= 1'b0;
      zero_acc <= 1'b1;
    end else if (accept) begin
      carry_q  <= bus.in_cout;
      zero_acc <= zero_new;
    end
  end

endmodule

// File: tb/tb_adder_result_stage.sv
// tb/tb_adder_result_stage.sv - directed self-checking bench for adder_result_stage
module tb_adder_result_stage;

  logic clk;
  logic rst_n;
  logic cin_ext;
  logic adder_cin;
  int   checks;
  int   errors;

  logic [7:0] got_sum[$];
  logic [3:0] got_flags[$];

  adder_result_stage_if #(.width(8)) bus ();

  adder_result_stage #(.width(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cin_ext   (cin_ext),
    .adder_cin (adder_cin),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every word that leaves the stage, sampled mid-cycle before the draining edge.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      got_sum.push_back(bus.out_sum);
      got_flags.push_back(bus.out_flags);
    end
  end

  task automatic set_word(input logic first, input logic last, input logic [7:0] sum,
                          input logic cout, input logic amsb, input logic bmsb);
    bus.in_first = first;
    bus.in_last  = last;
    bus.in_sum   = sum;
    bus.in_cout  = cout;
    bus.in_a_msb = amsb;
    bus.in_b_msb = bmsb;
  endtask

  // Holds in_valid until accepted; returns 1ns after the accepting edge with in_valid still high.
  task automatic send(input logic first, input logic last, input logic [7:0] sum,
                      input logic cout, input logic amsb, input logic bmsb, output int waited);
    logic rdy;
    logic acc;
    acc = 1'b0;
    waited = 0;
    set_word(first, last, sum, cout, amsb, bmsb);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      waited++;
      if (rdy) begin
        acc = 1'b1;
        break;
      end
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout: sum %h not accepted within %0d cycles", sum, waited);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n         = 1'b0;
    cin_ext       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    set_word(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    #12;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", bus.in_ready); end
    checks++; if (bus.out_sum !== 8'h00) begin errors++; $display("FAIL reset_out_sum: got %h exp 00", bus.out_sum); end
    checks++; if (bus.out_flags !== 4'b0000) begin errors++; $display("FAIL reset_out_flags: got %b exp 0000", bus.out_flags); end
    checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b exp 0", bus.out_last); end
    checks++; if (adder_cin !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b exp 0", adder_cin); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_one_word;
    int w;
    cin_ext = 1'b0;
    set_word(1'b1, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (adder_cin !== 1'b0) begin errors++; $display("FAIL one_word_cin: got %b exp 0", adder_cin); end
    send(1'b1, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0, w);
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL one_word_valid: got %b exp 1", bus.out_valid); end
    checks++; if (bus.out_sum !== 8'h80) begin errors++; $display("FAIL one_word_sum: got %h exp 80", bus.out_sum); end
    checks++; if (bus.out_flags !== 4'b1001) begin errors++; $display("FAIL one_word_flags: got %b exp 1001", bus.out_flags); end
    checks++; if (bus.out_last !== 1'b1) begin errors++; $display("FAIL one_word_last: got %b exp 1", bus.out_last); end
    idle_cycles(1);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL one_word_drained: got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_two_word;
    int w;
    cin_ext = 1'b0;
    send(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, w);
    set_word(1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (adder_cin !== 1'b1) begin errors++; $display("FAIL two_word_chain_cin: got %b exp 1", adder_cin); end
    checks++; if (bus.out_flags !== 4'b0000) begin errors++; $display("FAIL two_word_low_flags: got %b exp 0000", bus.out_flags); end
    checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL two_word_low_last: got %b exp 0", bus.out_last); end
    send(1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, w);
    bus.in_valid = 1'b0;
    checks++; if (bus.out_sum !== 8'h01) begin errors++; $display("FAIL two_word_hi_sum: got %h exp 01", bus.out_sum); end
    checks++; if (bus.out_flags !== 4'b0000) begin errors++; $display("FAIL two_word_hi_flags: got %b exp 0000", bus.out_flags); end
    idle_cycles(1);
    send(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, w);
    set_word(1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
    #1;
    checks++; if (adder_cin !== 1'b1) begin errors++; $display("FAIL two_word_ffff_cin: got %b exp 1", adder_cin); end
    send(1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, w);
    bus.in_valid = 1'b0;
    checks++; if (bus.out_flags !== 4'b0110) begin errors++; $display("FAIL two_word_ffff_flags: got %b exp 0110", bus.out_flags); end
    idle_cycles(1);
  endtask

  task automatic test_backpressure;
    int w;
    got_sum.delete();
    got_flags.delete();
    bus.out_ready = 1'b0;
    send(1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, w);
    send(1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, w);
    set_word(1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full: got %b exp 0", bus.in_ready); end
    checks++; if (bus.out_sum !== 8'h11) begin errors++; $display("FAIL bp_head_sum: got %h exp 11", bus.out_sum); end
    idle_cycles(3);
    @(negedge clk);
    checks++; if (bus.out_sum !== 8'h11) begin errors++; $display("FAIL bp_stable_sum: got %h exp 11", bus.out_sum); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_stable_valid: got %b exp 1", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_stable_ready: got %b exp 0", bus.in_ready); end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, w);
    bus.in_valid = 1'b0;
    checks++; if (w !== 2) begin errors++; $display("FAIL bp_third_wait: got %0d exp 2", w); end
    idle_cycles(3);
    checks++; if (got_sum.size() !== 3) begin errors++; $display("FAIL bp_count: got %0d exp 3", got_sum.size()); end
    if (got_sum.size() == 3) begin
      checks++; if (got_sum[0] !== 8'h11) begin errors++; $display("FAIL bp_order0: got %h exp 11", got_sum[0]); end
      checks++; if (got_sum[1] !== 8'h22) begin errors++; $display("FAIL bp_order1: got %h exp 22", got_sum[1]); end
      checks++; if (got_sum[2] !== 8'h33) begin errors++; $display("FAIL bp_order2: got %h exp 33", got_sum[2]); end
    end
  endtask

  task automatic test_back_to_back;
    int w;
    int total;
    logic [7:0] exp_sum [6];
    exp_sum = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
    got_sum.delete();
    got_flags.delete();
    bus.out_ready = 1'b0;
    send(1'b1, 1'b1, exp_sum[0], 1'b0, 1'b0, 1'b0, w);
    send(1'b1, 1'b1, exp_sum[1], 1'b0, 1'b0, 1'b0, w);
    bus.out_ready = 1'b1;
    total = 0;
    for (int i = 2; i < 6; i++) begin
      send(1'b1, 1'b1, exp_sum[i], 1'b0, 1'b0, 1'b0, w);
      total += w;
    end
    bus.in_valid = 1'b0;
    checks++; if (total !== 5) begin errors++; $display("FAIL b2b_cycles: got %0d exp 5", total); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_steady: got %b exp 1", bus.in_ready); end
    idle_cycles(3);
    checks++; if (got_sum.size() !== 6) begin errors++; $display("FAIL b2b_count: got %0d exp 6", got_sum.size()); end
    for (int i = 0; i < 6; i++) begin
      if (i < got_sum.size()) begin
        checks++;
        if (got_sum[i] !== exp_sum[i]) begin
          errors++;
          $display("FAIL b2b_order%0d: got %h exp %h", i, got_sum[i], exp_sum[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int w;
    cin_ext = 1'b0;
    bus.out_ready = 1'b0;
    send(1'b1, 1'b0, 8'hAA, 1'b1, 1'b0, 1'b0, w);
    send(1'b0, 1'b0, 8'hBB, 1'b1, 1'b0, 1'b0, w);
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    #1;
    checks++; if (adder_cin !== 1'b1) begin errors++; $display("FAIL mid_pre_carry: got %b exp 1", adder_cin); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mid_pre_full: got %b exp 0", bus.in_ready); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b exp 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b exp 1", bus.in_ready); end
    checks++; if (adder_cin !== 1'b0) begin errors++; $display("FAIL mid_rst_carry: got %b exp 0", adder_cin); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cin_ext = 1'b1;
    set_word(1'b1, 1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (adder_cin !== 1'b1) begin errors++; $display("FAIL mid_new_cin: got %b exp 1", adder_cin); end
    send(1'b1, 1'b1, 8'h05, 1'b0, 1'b0, 1'b0, w);
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.out_sum !== 8'h05) begin errors++; $display("FAIL mid_new_sum: got %h exp 05", bus.out_sum); end
    checks++; if (bus.out_flags !== 4'b0000) begin errors++; $display("FAIL mid_new_flags: got %b exp 0000", bus.out_flags); end
    bus.out_ready = 1'b1;
    cin_ext = 1'b0;
    idle_cycles(2);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_drained: got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_restart;
    int w;
    cin_ext = 1'b0;
    bus.out_ready = 1'b1;
    send(1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, w);
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.out_flags !== 4'b0000) begin errors++; $display("FAIL restart_nonlast_flags: got %b exp 0000", bus.out_flags); end
    checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL restart_nonlast_last: got %b exp 0", bus.out_last); end
    @(posedge clk);
    #1;
    set_word(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (adder_cin !== 1'b0) begin errors++; $display("FAIL restart_cin: got %b exp 0", adder_cin); end
    send(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, w);
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.out_flags !== 4'b0100) begin errors++; $display("FAIL restart_zero_flags: got %b exp 0100", bus.out_flags); end
    idle_cycles(2);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_one_word();
    test_two_word();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_restart();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
